// File: rtl/bp_me_mem_arbiter_2to1_if.sv
// Bus bundle for the 2:1 memory arbiter: two UCE-facing ports and one memory-facing channel.
// The slave modport is the arbiter's view; the master modport is the view of the surrounding agents.
interface bp_me_mem_arbiter_2to1_if #(
   parameter int msg_width_p       = 128,
   parameter int max_outstanding_p = 4
);
   localparam int cnt_w_lp = $clog2(max_outstanding_p) + 1;

   logic [2*msg_width_p-1:0] cmd_i;
   logic [1:0]               cmd_v_i;
   logic [1:0]               cmd_ready_o;
   logic [msg_width_p-1:0]   mem_cmd_o;
   logic                     mem_cmd_v_o;
   logic                     mem_cmd_ready_i;
   logic [msg_width_p-1:0]   mem_resp_i;
   logic                     mem_resp_v_i;
   logic                     mem_resp_yumi_o;
   logic [msg_width_p-1:0]   resp_o;
   logic [1:0]               resp_v_o;
   logic [1:0]               resp_yumi_i;
   logic [2*cnt_w_lp-1:0]    outstanding_o;
   logic                     err_o;

   modport slave (
      input  cmd_i, cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_yumi_i,
      output cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, resp_o, resp_v_o,
             outstanding_o, err_o
   );

   modport master (
      output cmd_i, cmd_v_i, mem_cmd_ready_i, mem_resp_i, mem_resp_v_i, resp_yumi_i,
      input  cmd_ready_o, mem_cmd_o, mem_cmd_v_o, mem_resp_yumi_o, resp_o, resp_v_o,
             outstanding_o, err_o
   );
endinterface

// File: rtl/bp_me_mem_arbiter_2to1.sv
// Round-robin 2:1 arbiter onto one memory command channel; an in-order tag FIFO
// remembers which port issued each command so responses return to their owner.
module bp_me_mem_arbiter_2to1 #(
   parameter int msg_width_p       = 128,
   parameter int max_outstanding_p = 4
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   bp_me_mem_arbiter_2to1_if.slave   bus
);
   localparam int ptr_w_lp = $clog2(max_outstanding_p);
   localparam int cnt_w_lp = ptr_w_lp + 1;

   logic                               r_lock, r_grant, r_ptr, r_err;
   logic [max_outstanding_p-1:0]       r_tags;
   logic [ptr_w_lp-1:0]                r_wptr, r_rptr;
   logic [cnt_w_lp-1:0]                r_cnt;
   logic [1:0][cnt_w_lp-1:0]           r_out;

   logic       w_full, w_empty, w_grant, w_head, w_push, w_pop;
   logic       w_cmd_v, w_resp_yumi;
   logic [1:0] w_cmd_ready, w_resp_v, w_inc, w_dec;

   always_comb begin
      w_full  = (r_cnt == cnt_w_lp'(max_outstanding_p));
      w_empty = (r_cnt == '0);

      // A stalled command keeps its port until memory takes it.
      if (r_lock)                       w_grant = r_grant;
      else if (bus.cmd_v_i == 2'b01)    w_grant = 1'b0;
      else if (bus.cmd_v_i == 2'b10)    w_grant = 1'b1;
      else                              w_grant = r_ptr;

      w_cmd_v              = ~reset_i & (|bus.cmd_v_i) & ~w_full;
      w_cmd_ready          = 2'b00;
      w_cmd_ready[w_grant] = ~reset_i & bus.mem_cmd_ready_i & ~w_full;
      w_push               = w_cmd_v & bus.mem_cmd_ready_i & bus.cmd_v_i[w_grant];

      w_head           = r_tags[r_rptr];
      w_resp_v         = 2'b00;
      w_resp_v[w_head] = ~reset_i & bus.mem_resp_v_i & ~w_empty;
      w_resp_yumi      = bus.resp_yumi_i[w_head] & w_resp_v[w_head];
      w_pop            = w_resp_yumi;

      w_inc = 2'b00;
      w_dec = 2'b00;
      if (w_push) w_inc[w_grant] = 1'b1;
      if (w_pop)  w_dec[w_head]  = 1'b1;
   end

   assign bus.mem_cmd_v_o     = w_cmd_v;
   assign bus.mem_cmd_o       = w_grant ? bus.cmd_i[2*msg_width_p-1:msg_width_p]
                                        : bus.cmd_i[msg_width_p-1:0];
   assign bus.cmd_ready_o     = w_cmd_ready;
   assign bus.resp_o          = bus.mem_resp_i;
   assign bus.resp_v_o        = w_resp_v;
   assign bus.mem_resp_yumi_o = w_resp_yumi;
   assign bus.outstanding_o   = {r_out[1], r_out[0]};
   assign bus.err_o           = r_err;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         r_lock  <= 1'b0;
         r_grant <= 1'b0;
         r_ptr   <= 1'b0;
         r_err   <= 1'b0;
         r_tags  <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_cnt   <= '0;
         r_out   <= '0;
      end else begin
         if (w_cmd_v && !bus.mem_cmd_ready_i) begin
            r_lock  <= 1'b1;
            r_grant <= w_grant;
         end else if (w_push) begin
            r_lock  <= 1'b0;
         end

         if (w_push) begin
            r_tags[r_wptr] <= w_grant;
            r_wptr         <= r_wptr + 1'b1;
            r_ptr          <= ~w_grant;
         end
         if (w_pop) r_rptr <= r_rptr + 1'b1;

         r_cnt <= r_cnt + cnt_w_lp'(w_push) - cnt_w_lp'(w_pop);
         for (int p = 0; p < 2; p++)
            r_out[p] <= r_out[p] + cnt_w_lp'(w_inc[p]) - cnt_w_lp'(w_dec[p]);

         // A response with nothing outstanding can never be routed; flag it until reset.
         if (bus.mem_resp_v_i && w_empty) r_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bp_me_mem_arbiter_2to1.sv
// Vector-table bench for the 2:1 memory arbiter with an issue-order scoreboard on responses.
module tb_bp_me_mem_arbiter_2to1;
   localparam int MW = 128;
   localparam int MO = 4;
   localparam int CW = $clog2(MO) + 1;
   localparam logic [MW-1:0] D0 = {32'hC0DE_0000, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
   localparam logic [MW-1:0] D1 = {32'hBEEF_0001, 32'h4444_4444, 32'h5555_5555, 32'h6666_6666};

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   bp_me_mem_arbiter_2to1_if #(.msg_width_p(MW), .max_outstanding_p(MO)) bus ();

   bp_me_mem_arbiter_2to1 #(.msg_width_p(MW), .max_outstanding_p(MO)) dut (
      .clk_i   (clk),
      .reset_i (rst),
      .bus     (bus.slave)
   );

   typedef struct {
      logic [1:0] cv;  logic rdy; logic rv; logic [1:0] ry;
      logic mcv; logic [1:0] crdy; logic g; logic [1:0] rvo; logic my;
      logic [CW-1:0] o0, o1; logic err;
   } row_t;

   int   checks = 0;
   int   errors = 0;
   logic q[$];
   row_t tbl[$];

   function automatic row_t mk(logic [1:0] cv, logic rdy, logic rv, logic [1:0] ry,
                               logic mcv, logic [1:0] crdy, logic g, logic [1:0] rvo,
                               logic my, int o0, int o1, logic err);
      row_t r;
      r.cv = cv; r.rdy = rdy; r.rv = rv; r.ry = ry;
      r.mcv = mcv; r.crdy = crdy; r.g = g; r.rvo = rvo; r.my = my;
      r.o0 = CW'(o0); r.o1 = CW'(o1); r.err = err;
      return r;
   endfunction

   task automatic chk(input string n, input logic [MW-1:0] a, input logic [MW-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", n, a, e);
      end
   endtask

   task automatic apply(input row_t r, input string n);
      logic [MW-1:0] rdata;
      logic          e;
      rdata = {$urandom, $urandom, $urandom, $urandom};
      bus.cmd_v_i = r.cv; bus.mem_cmd_ready_i = r.rdy;
      bus.mem_resp_v_i = r.rv; bus.resp_yumi_i = r.ry; bus.mem_resp_i = rdata;
      #3;
      chk({n, ".mem_cmd_v"}, MW'(bus.mem_cmd_v_o), MW'(r.mcv));
      if (r.mcv) chk({n, ".mem_cmd"}, bus.mem_cmd_o, r.g ? D1 : D0);
      chk({n, ".cmd_ready"}, MW'(bus.cmd_ready_o), MW'(r.crdy));
      chk({n, ".resp_v"}, MW'(bus.resp_v_o), MW'(r.rvo));
      chk({n, ".mem_yumi"}, MW'(bus.mem_resp_yumi_o), MW'(r.my));
      chk({n, ".resp_data"}, bus.resp_o, rdata);
      chk({n, ".out0"}, MW'(bus.outstanding_o[CW-1:0]), MW'(r.o0));
      chk({n, ".out1"}, MW'(bus.outstanding_o[2*CW-1:CW]), MW'(r.o1));
      chk({n, ".err"}, MW'(bus.err_o), MW'(r.err));
      if (r.mcv && r.rdy) q.push_back(r.g);
      if (bus.mem_resp_yumi_o) begin
         if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s.sb_underflow actual=yumi expected=no_yumi", n);
         end else begin
            e = q.pop_front();
            chk({n, ".sb_tag"}, MW'(bus.resp_v_o), e ? MW'(2'b10) : MW'(2'b01));
         end
      end
      @(posedge clk); #1;
   endtask

   // Reset asserted mid-cycle with every input active; outputs must drop at once.
   task automatic do_reset(input string n);
      bus.cmd_v_i = 2'b11; bus.mem_cmd_ready_i = 1'b1;
      bus.mem_resp_v_i = 1'b1; bus.resp_yumi_i = 2'b11;
      #2 rst = 1'b1;
      #1;
      chk({n, ".mem_cmd_v"}, MW'(bus.mem_cmd_v_o), '0);
      chk({n, ".cmd_ready"}, MW'(bus.cmd_ready_o), '0);
      chk({n, ".resp_v"}, MW'(bus.resp_v_o), '0);
      chk({n, ".mem_yumi"}, MW'(bus.mem_resp_yumi_o), '0);
      chk({n, ".outstanding"}, MW'(bus.outstanding_o), '0);
      chk({n, ".err"}, MW'(bus.err_o), '0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      bus.cmd_v_i = 2'b00; bus.mem_cmd_ready_i = 1'b0;
      bus.mem_resp_v_i = 1'b0; bus.resp_yumi_i = 2'b00;
   endtask

   initial begin
      bus.cmd_i = {D1, D0};
      bus.mem_resp_i = '0;

      //            cv    rdy rv ry     mcv crdy  g  rvo   my o0 o1 err
      tbl.push_back(mk(2'b00,1,0,2'b00, 0,2'b01,0,2'b00,0, 0,0,0));
      tbl.push_back(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 0,0,0));
      tbl.push_back(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 1,0,0));
      tbl.push_back(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 2,0,0));
      tbl.push_back(mk(2'b00,1,1,2'b01, 0,2'b10,0,2'b01,1, 3,0,0));
      tbl.push_back(mk(2'b00,1,1,2'b01, 0,2'b10,0,2'b01,1, 2,0,0));
      tbl.push_back(mk(2'b00,1,1,2'b01, 0,2'b10,0,2'b01,1, 1,0,0));
      tbl.push_back(mk(2'b00,1,0,2'b00, 0,2'b10,0,2'b00,0, 0,0,0));
      tbl.push_back(mk(2'b11,1,0,2'b00, 1,2'b10,1,2'b00,0, 0,0,0));
      tbl.push_back(mk(2'b11,1,0,2'b00, 1,2'b01,0,2'b00,0, 0,1,0));
      tbl.push_back(mk(2'b11,1,0,2'b00, 1,2'b10,1,2'b00,0, 1,1,0));
      tbl.push_back(mk(2'b11,1,0,2'b00, 1,2'b01,0,2'b00,0, 1,2,0));
      tbl.push_back(mk(2'b11,1,1,2'b10, 0,2'b00,0,2'b10,1, 2,2,0));
      tbl.push_back(mk(2'b11,1,0,2'b00, 1,2'b10,1,2'b00,0, 2,1,0));
      tbl.push_back(mk(2'b00,1,1,2'b11, 0,2'b00,0,2'b01,1, 2,2,0));
      tbl.push_back(mk(2'b00,1,1,2'b01, 0,2'b01,0,2'b10,0, 1,2,0));
      tbl.push_back(mk(2'b00,1,1,2'b10, 0,2'b01,0,2'b10,1, 1,2,0));
      tbl.push_back(mk(2'b00,1,1,2'b01, 0,2'b01,0,2'b01,1, 1,1,0));
      tbl.push_back(mk(2'b00,1,1,2'b10, 0,2'b01,0,2'b10,1, 0,1,0));
      tbl.push_back(mk(2'b00,1,1,2'b11, 0,2'b01,0,2'b00,0, 0,0,0));
      tbl.push_back(mk(2'b00,1,0,2'b00, 0,2'b01,0,2'b00,0, 0,0,1));

      do_reset("rst0");
      foreach (tbl[i]) apply(tbl[i], $sformatf("tbl%0d", i));

      // Grant held on port 0 while memory stalls, even though the pointer names port 1.
      do_reset("rst1");
      apply(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 0,0,0), "lk_pre");
      apply(mk(2'b01,0,0,2'b00, 1,2'b00,0,2'b00,0, 1,0,0), "lk0");
      apply(mk(2'b11,0,0,2'b00, 1,2'b00,0,2'b00,0, 1,0,0), "lk1");
      apply(mk(2'b11,0,0,2'b00, 1,2'b00,0,2'b00,0, 1,0,0), "lk2");
      apply(mk(2'b11,1,0,2'b00, 1,2'b01,0,2'b00,0, 1,0,0), "lk3");
      apply(mk(2'b11,1,0,2'b00, 1,2'b10,1,2'b00,0, 2,0,0), "lk4");

      // Issue order 1,0,1 with the first response's yumi withheld two cycles.
      do_reset("rst2");
      apply(mk(2'b10,1,0,2'b00, 1,2'b10,1,2'b00,0, 0,0,0), "ord0");
      apply(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 0,1,0), "ord1");
      apply(mk(2'b10,1,0,2'b00, 1,2'b10,1,2'b00,0, 1,1,0), "ord2");
      apply(mk(2'b00,1,1,2'b00, 0,2'b01,0,2'b10,0, 1,2,0), "hold0");
      apply(mk(2'b00,1,1,2'b00, 0,2'b01,0,2'b10,0, 1,2,0), "hold1");
      apply(mk(2'b00,1,1,2'b10, 0,2'b01,0,2'b10,1, 1,2,0), "rsp0");
      apply(mk(2'b00,1,1,2'b01, 0,2'b01,0,2'b01,1, 1,1,0), "rsp1");
      apply(mk(2'b00,1,1,2'b10, 0,2'b01,0,2'b10,1, 0,1,0), "rsp2");

      // Same-port push and pop in one cycle.
      apply(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 0,0,0), "pp0");
      apply(mk(2'b01,1,1,2'b01, 1,2'b01,0,2'b01,1, 1,0,0), "pp1");
      apply(mk(2'b00,1,1,2'b01, 0,2'b10,0,2'b01,1, 1,0,0), "pp2");

      // Response on empty FIFO while a command is pushed: no match, error latched.
      apply(mk(2'b10,1,1,2'b10, 1,2'b10,1,2'b00,0, 0,0,0), "emp0");
      apply(mk(2'b01,1,0,2'b00, 1,2'b01,0,2'b00,0, 0,1,1), "emp1");

      // Reset with two commands in flight; a stale response afterwards is an error.
      do_reset("rst3");
      apply(mk(2'b00,0,1,2'b11, 0,2'b00,0,2'b00,0, 0,0,0), "stale0");
      apply(mk(2'b00,0,0,2'b00, 0,2'b00,0,2'b00,0, 0,0,1), "stale1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
